writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/wb_pkg.sv | 37 +++
 rtl/wb_fifo.sv | 78 +++++++
 rtl/writeback_unit.sv | 144 ++++++++++++++
 tb/tb_writeback_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback unit: result request record, write-back
// source select and the data-select helper used at pop time.
package wb_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] alu_out;
        logic [XLEN_DEFAULT-1:0] mem_data;
        logic [XLEN_DEFAULT-1:0] sextimm;
        logic [4:0]              rd;
        logic                    wen;
        wb_sel_e                 wbsel;
    } wb_req_t;

    // Pick the register-file write value; pc+4 wraps naturally at XLEN bits.
    function automatic logic [XLEN_DEFAULT-1:0] wb_select(input wb_req_t req);
        logic [XLEN_DEFAULT-1:0] data;
        case (req.wbsel)
            WB_ALU:  data = req.alu_out;
            WB_MEM:  data = req.mem_data;
            WB_PC4:  data = req.pc + XLEN_DEFAULT'(4);
            WB_IMM:  data = req.sextimm;
            default: data = req.alu_out;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-channel result buffer. Circular FIFO of DEPTH entries; also exposes
// every slot plus an occupancy mask so the parent can see pending writes.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  T                 din,
    output T                 dout,
    output logic             full,
    output logic             empty,
    output T                 slots [DEPTH],
    output logic [DEPTH-1:0] slot_valid
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;
    logic [AW-1:0]  offset;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Flush and reset suppress any transfer in that cycle.
    assign do_push = push && !full && !flush && reset;
    assign do_pop  = pop && !empty && !flush && reset;
    assign dout    = mem[rd_ptr];
    assign slots   = mem;

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        offset     = '0;
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset        = AW'(i) - rd_ptr;
            slot_valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: NCH independent result buffers, one round-robin retirement
// per cycle into registered register-file write and commit outputs, plus a
// scoreboard of registers with pending buffered writes.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DEPTH = 2,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   in_ready,
    input  wb_req_t          in_req [NCH],
    output logic             rf_wen,
    output logic [4:0]       rf_wa,
    output logic [XLEN-1:0]  rf_wd,
    output logic             commit_valid,
    output logic [XLEN-1:0]  commit_pc,
    output logic [31:0]      busy_mask
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    wb_req_t                 head [NCH];
    logic [NCH-1:0]          full;
    logic [NCH-1:0]          empty;
    logic [NCH-1:0]          pop_vec;
    logic [NCH-1:0][31:0]    busy_vec;

    logic [CW-1:0]           last_grant;
    logic [CW-1:0]           grant_idx;
    logic                    grant_any;
    logic                    pop_fire;
    int                      cand;
    wb_req_t                 popped;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        wb_req_t          ch_slots [DEPTH];
        logic [DEPTH-1:0] ch_valid;
        logic [31:0]      ch_busy;

        wb_fifo #(
            .DEPTH (DEPTH),
            .T     (wb_req_t)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .push       (in_valid[c]),
            .pop        (pop_vec[c]),
            .din        (in_req[c]),
            .dout       (head[c]),
            .full       (full[c]),
            .empty      (empty[c]),
            .slots      (ch_slots),
            .slot_valid (ch_valid)
        );

        // Registers this channel still intends to write.
        always_comb begin
            ch_busy = '0;
            for (int s = 0; s < DEPTH; s++) begin
                if (ch_valid[s] && ch_slots[s].wen) begin
                    ch_busy[ch_slots[s].rd] = 1'b1;
                end
            end
        end

        assign busy_vec[c] = ch_busy;
    end

    // Ready depends only on occupancy, never on a same-cycle pop.
    assign in_ready = ~full;

    // Round-robin: scan channels starting just after the last winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant;
        cand      = 0;
        for (int k = 1; k <= NCH; k++) begin
            cand = (int'(last_grant) + k) % NCH;
            if (!grant_any && !empty[cand]) begin
                grant_any = 1'b1;
                grant_idx = CW'(cand);
            end
        end
    end

    assign pop_fire = grant_any && !flush;
    assign popped   = head[grant_idx];

    // One-hot pop request towards the winning channel.
    always_comb begin
        pop_vec = '0;
        for (int c = 0; c < NCH; c++) begin
            pop_vec[c] = pop_fire && (grant_idx == CW'(c));
        end
    end

    // Arbitration pointer moves only on a grant; restart so channel 0 wins next.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            last_grant <= CW'(NCH - 1);
        end else if (pop_fire) begin
            last_grant <= grant_idx;
        end
    end

    // Retirement register: loaded on the pop edge, pulses drop when idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_wen       <= 1'b0;
            rf_wa        <= '0;
            rf_wd        <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else if (flush) begin
            rf_wen       <= 1'b0;
            commit_valid <= 1'b0;
        end else if (pop_fire) begin
            rf_wen       <= popped.wen && (popped.rd != 5'd0);
            rf_wa        <= popped.rd;
            rf_wd        <= XLEN'(wb_select(popped));
            commit_valid <= 1'b1;
            commit_pc    <= XLEN'(popped.pc);
        end else begin
            rf_wen       <= 1'b0;
            commit_valid <= 1'b0;
        end
    end

    // Merge per-channel pending writes; x0 is never reported busy.
    always_comb begin
        busy_mask = '0;
        for (int c = 0; c < NCH; c++) begin
            busy_mask = busy_mask | busy_vec[c];
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: reset values, a vector table of single results,
// hand sequences for arbitration, hazard scoreboard, flush and reset, then
// random traffic checked against a queue-based reference model.
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int NCH   = 2;
    localparam int DEPTH = 2;
    localparam int XLEN  = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    wb_req_t          in_req [NCH];
    logic             rf_wen;
    logic [4:0]       rf_wa;
    logic [XLEN-1:0]  rf_wd;
    logic             commit_valid;
    logic [XLEN-1:0]  commit_pc;
    logic [31:0]      busy_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_unit #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_req       (in_req),
        .rf_wen       (rf_wen),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .busy_mask    (busy_mask)
    );

    // Reference model state: one queue per channel plus retirement outputs.
    wb_req_t      mq [NCH][$];
    int           m_last;
    logic         m_wen;
    logic         m_cv;
    logic [4:0]   m_wa;
    logic [63:0]  m_wd;
    logic [63:0]  m_pc;

    function automatic logic [63:0] ref_data(input wb_req_t e);
        if (e.wbsel == WB_ALU)      return e.alu_out;
        else if (e.wbsel == WB_MEM) return e.mem_data;
        else if (e.wbsel == WB_PC4) return e.pc + 64'd4;
        else                        return e.sextimm;
    endfunction

    function automatic wb_req_t mk(input logic [63:0] pc, input logic [63:0] alu,
                                   input logic [63:0] mem, input logic [63:0] imm,
                                   input logic [4:0] rd, input logic wen,
                                   input logic [1:0] sel);
        wb_req_t r;
        r.pc = pc; r.alu_out = alu; r.mem_data = mem; r.sextimm = imm;
        r.rd = rd; r.wen = wen; r.wbsel = wb_sel_e'(sel);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Predict what the coming clock edge does to the model.
    task automatic model_edge();
        bit          acc [NCH];
        bit          got;
        int          gc;
        int          c;
        wb_req_t     e;
        if (!reset) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            m_last = NCH - 1;
            m_wen = 0; m_cv = 0; m_wa = 0; m_wd = 0; m_pc = 0;
        end else if (flush) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            m_last = NCH - 1;
            m_wen = 0; m_cv = 0;
        end else begin
            for (int i = 0; i < NCH; i++) acc[i] = in_valid[i] && (mq[i].size() < DEPTH);
            got = 0; gc = 0;
            for (int k = 1; k <= NCH; k++) begin
                c = (m_last + k) % NCH;
                if (!got && mq[c].size() > 0) begin got = 1; gc = c; end
            end
            if (got) begin
                e      = mq[gc].pop_front();
                m_last = gc;
                m_cv   = 1;
                m_pc   = e.pc;
                m_wa   = e.rd;
                m_wd   = ref_data(e);
                m_wen  = e.wen && (e.rd != 0);
            end else begin
                m_cv = 0; m_wen = 0;
            end
            for (int i = 0; i < NCH; i++) if (acc[i]) mq[i].push_back(in_req[i]);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCH-1:0] exp_rdy;
        logic [31:0]    exp_busy;
        exp_busy = '0;
        for (int i = 0; i < NCH; i++) begin
            exp_rdy[i] = (mq[i].size() != DEPTH);
            foreach (mq[i][j]) if (mq[i][j].wen && mq[i][j].rd != 0) exp_busy[mq[i][j].rd] = 1'b1;
        end
        chk({tag, " commit_valid"}, 64'(commit_valid), 64'(m_cv));
        chk({tag, " rf_wen"},       64'(rf_wen),       64'(m_wen));
        chk({tag, " rf_wa"},        64'(rf_wa),        64'(m_wa));
        chk({tag, " rf_wd"},        rf_wd,             m_wd);
        chk({tag, " commit_pc"},    commit_pc,         m_pc);
        chk({tag, " in_ready"},     64'(in_ready),     64'(exp_rdy));
        chk({tag, " busy_mask"},    64'(busy_mask),    64'(exp_busy));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        reset = 1'b1; flush = 1'b0; in_valid = '0;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b0;
        step("reset");
        reset = 1'b1;
    endtask

    typedef struct {
        logic [63:0] pc, alu, mem, imm;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  sel;
        logic        exp_wen;
        logic [63:0] exp_wd;
    } vec_t;

    vec_t vt [6];

    initial begin
        vt[0] = '{64'h1000, 64'h0, 64'h0, 64'h0, 5'd5, 1'b1, 2'b10, 1'b1, 64'h1004};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 64'h0, 5'd3, 1'b1, 2'b10, 1'b1, 64'h0};
        vt[2] = '{64'h2000, 64'hFF, 64'h0, 64'h0, 5'd0, 1'b1, 2'b00, 1'b0, 64'hFF};
        vt[3] = '{64'h2004, 64'h0, 64'h1234, 64'h0, 5'd9, 1'b1, 2'b01, 1'b1, 64'h1234};
        vt[4] = '{64'h2008, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 5'd31, 1'b0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FF80};
        vt[5] = '{64'h200C, 64'hDEAD_BEEF, 64'h0, 64'h0, 5'd1, 1'b1, 2'b00, 1'b1, 64'hDEAD_BEEF};

        for (int i = 0; i < NCH; i++) in_req[i] = mk(0, 0, 0, 0, 0, 0, 0);
        idle(); reset = 1'b0;
        step("reset");
        step("reset");
        chk("rst rf_wen", 64'(rf_wen), 0);
        chk("rst rf_wa", 64'(rf_wa), 0);
        chk("rst rf_wd", rf_wd, 0);
        chk("rst commit_valid", 64'(commit_valid), 0);
        chk("rst commit_pc", commit_pc, 0);
        chk("rst in_ready", 64'(in_ready), 64'h3);
        chk("rst busy_mask", 64'(busy_mask), 0);
        idle();

        // Vector table: one result on ch0, retired two edges later.
        for (int i = 0; i < 6; i++) begin
            idle();
            in_valid = 2'b01;
            in_req[0] = mk(vt[i].pc, vt[i].alu, vt[i].mem, vt[i].imm, vt[i].rd, vt[i].wen, vt[i].sel);
            step("vec push");
            idle();
            step("vec pop");
            chk("vec commit_valid", 64'(commit_valid), 1);
            chk("vec rf_wen", 64'(rf_wen), 64'(vt[i].exp_wen));
            chk("vec rf_wa", 64'(rf_wa), 64'(vt[i].rd));
            chk("vec rf_wd", rf_wd, vt[i].exp_wd);
            chk("vec commit_pc", commit_pc, vt[i].pc);
            step("vec idle");
            chk("vec idle commit_valid", 64'(commit_valid), 0);
        end

        // Both channels push continuously: commits alternate ch0/ch1 in order.
        do_reset();
        begin
            int      n [NCH];
            int      k;
            bit      acc [NCH];
            n[0] = 0; n[1] = 0; k = 0;
            for (int cyc = 0; cyc < 10; cyc++) begin
                idle(); in_valid = 2'b11;
                in_req[0] = mk(64'h100 + 64'(n[0]) * 8, 64'(n[0]), 0, 0, 5'd10, 1'b1, 2'b00);
                in_req[1] = mk(64'h200 + 64'(n[1]) * 8, 64'(n[1]), 0, 0, 5'd20, 1'b1, 2'b00);
                for (int c = 0; c < NCH; c++) acc[c] = in_ready[c];
                step("alt");
                for (int c = 0; c < NCH; c++) if (acc[c]) n[c]++;
                if (cyc >= 1 && cyc <= 8) begin
                    chk("alt order", commit_pc, ((k % 2) ? 64'h200 : 64'h100) + 64'(k / 2) * 8);
                    k++;
                end
            end
        end

        // Pending rd=7 waits behind ch1 in arbitration; scoreboard tracks it.
        do_reset();
        idle(); in_valid = 2'b11;
        in_req[0] = mk(64'h300, 0, 0, 0, 5'd2, 1'b1, 2'b00);
        in_req[1] = mk(64'h400, 0, 0, 0, 5'd3, 1'b1, 2'b00);
        step("hz1");
        in_req[0] = mk(64'h304, 0, 0, 0, 5'd7, 1'b1, 2'b00);
        in_req[1] = mk(64'h404, 0, 0, 0, 5'd4, 1'b1, 2'b00);
        step("hz2");
        chk("hz busy7 queued", 64'(busy_mask[7]), 1);
        idle();
        step("hz3");
        chk("hz busy7 held", 64'(busy_mask[7]), 1);
        chk("hz ch1 first", 64'(rf_wa), 3);
        step("hz4");
        chk("hz busy7 cleared", 64'(busy_mask[7]), 0);
        chk("hz rd7 retired", 64'(rf_wa), 7);

        // Flush with buffers full, then pointer restart.
        do_reset();
        idle(); in_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            in_req[0] = mk(64'h500 + 64'(i) * 4, 0, 0, 0, 5'(11 + i), 1'b1, 2'b00);
            in_req[1] = mk(64'h600 + 64'(i) * 4, 0, 0, 0, 5'(21 + i), 1'b1, 2'b00);
            step("fl fill");
        end
        flush = 1'b1;
        step("flush");
        chk("flush commit_valid", 64'(commit_valid), 0);
        chk("flush rf_wen", 64'(rf_wen), 0);
        chk("flush busy_mask", 64'(busy_mask), 0);
        chk("flush in_ready", 64'(in_ready), 64'h3);
        idle(); in_valid = 2'b11;
        in_req[0] = mk(64'h700, 0, 0, 0, 5'd1, 1'b1, 2'b00);
        in_req[1] = mk(64'h800, 0, 0, 0, 5'd2, 1'b1, 2'b00);
        step("fl push");
        idle();
        step("fl pop");
        chk("flush ptr ch0 first", commit_pc, 64'h700);

        // Same fill, then reset mid-operation.
        idle(); in_valid = 2'b11;
        for (int i = 0; i < 3; i++) step("rs fill");
        reset = 1'b0; flush = 1'b1;
        step("rs mid");
        chk("mid rst rf_wen", 64'(rf_wen), 0);
        chk("mid rst rf_wa", 64'(rf_wa), 0);
        chk("mid rst rf_wd", rf_wd, 0);
        chk("mid rst commit_valid", 64'(commit_valid), 0);
        chk("mid rst commit_pc", commit_pc, 0);
        chk("mid rst busy_mask", 64'(busy_mask), 0);
        chk("mid rst in_ready", 64'(in_ready), 64'h3);
        idle();
        step("rs after");
        chk("mid rst no pulse", 64'(rf_wen), 0);

        // Random traffic against the model.
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset = ($urandom_range(0, 99) != 0);
            flush = ($urandom_range(0, 39) == 0);
            in_valid = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                in_req[c] = mk(($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom},
                               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                               1'($urandom), 2'($urandom));
            end
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
